// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/flush controller: stall vector, branch/exception flush, event counters
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_mem_i,
  input  logic             mispredict_i,
  input  logic             ex_issue_mode_i,
  input  logic [31:0]      branch_pc_i,
  input  logic             exc_req_i,
  input  logic [31:0]      exc_pc_i,
  output logic [3:0]       stall_o,
  output logic             pc_stall_o,
  output logic             flush_o,
  output logic             flush_cause_o,
  output logic             ex_issue_mode_o,
  output logic [31:0]      new_pc_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic NO_FLUSH     = 1'b0;
  localparam logic FLUSH        = 1'b1;
  localparam logic CAUSE_BRANCH = 1'b0;
  localparam logic CAUSE_EXC    = 1'b1;
  localparam logic DUAL_ISSUE   = 1'b0;

  typedef enum logic [1:0] {IDLE, EXC_WAIT, EXC_FLUSH} state_t;

  state_t      state, state_next;
  logic [31:0] exc_pc_q;
  logic [3:0]  stall_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      exc_pc_q <= 32'h0;
    end else begin
      state <= state_next;
      if (state == IDLE && exc_req_i)
        exc_pc_q <= exc_pc_i;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (exc_req_i) state_next = stallreq_mem_i ? EXC_WAIT : EXC_FLUSH;
      EXC_WAIT:  if (!stallreq_mem_i) state_next = EXC_FLUSH;
      EXC_FLUSH: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Highest requesting stage wins; each request also holds every older stage.
  always_comb begin
    stall_req = 4'b0000;
    if (stallreq_mem_i)     stall_req = 4'b0111;
    else if (stallreq_ex_i) stall_req = 4'b0011;
    else if (stallreq_id_i) stall_req = 4'b0001;
  end

  // Outputs are forced to reset values while rst is low, even with requests pending.
  always_comb begin
    stall_o         = 4'b0000;
    pc_stall_o      = 1'b0;
    flush_o         = NO_FLUSH;
    flush_cause_o   = CAUSE_BRANCH;
    ex_issue_mode_o = DUAL_ISSUE;
    new_pc_o        = 32'h0;
    if (rst) begin
      case (state)
        IDLE: begin
          stall_o    = stall_req;
          pc_stall_o = |stall_req;
          // A same-cycle exception wipes the younger mispredicted pair anyway.
          if (mispredict_i && !stall_req[1] && !exc_req_i) begin
            flush_o         = FLUSH;
            flush_cause_o   = CAUSE_BRANCH;
            ex_issue_mode_o = ex_issue_mode_i;
            new_pc_o        = branch_pc_i;
          end
        end
        EXC_WAIT: begin
          stall_o    = 4'b1111;
          pc_stall_o = 1'b1;
        end
        EXC_FLUSH: begin
          flush_o       = FLUSH;
          flush_cause_o = CAUSE_EXC;
          new_pc_o      = exc_pc_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o != 4'b0000 && stall_cnt_o != {CNT_W{1'b1}})
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_o && flush_cnt_o != {CNT_W{1'b1}})
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic        mispredict_i, ex_issue_mode_i, exc_req_i;
  logic [31:0] branch_pc_i, exc_pc_i;
  logic [3:0]  stall_o;
  logic        pc_stall_o, flush_o, flush_cause_o, ex_issue_mode_o;
  logic [31:0] new_pc_o, stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_sc = 0;
  logic [31:0] exp_fc = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .mispredict_i(mispredict_i), .ex_issue_mode_i(ex_issue_mode_i), .branch_pc_i(branch_pc_i),
    .exc_req_i(exc_req_i), .exc_pc_i(exc_pc_i),
    .stall_o(stall_o), .pc_stall_o(pc_stall_o), .flush_o(flush_o), .flush_cause_o(flush_cause_o),
    .ex_issue_mode_o(ex_issue_mode_o), .new_pc_o(new_pc_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
    mispredict_i = 0; ex_issue_mode_i = 0; exc_req_i = 0;
    branch_pc_i = 0; exc_pc_i = 0;
  endtask

  // Checks one cycle's outputs mid-cycle, then advances past the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] e_stall, input logic e_flush,
                     input logic e_cause, input logic e_mode, input logic [31:0] e_pc);
    @(negedge clk);
    check({tag, ".stall"}, {28'h0, stall_o}, {28'h0, e_stall});
    check({tag, ".pc_stall"}, {31'h0, pc_stall_o}, {31'h0, |e_stall});
    check({tag, ".flush"}, {31'h0, flush_o}, {31'h0, e_flush});
    check({tag, ".cause"}, {31'h0, flush_cause_o}, {31'h0, e_cause});
    check({tag, ".mode"}, {31'h0, ex_issue_mode_o}, {31'h0, e_mode});
    check({tag, ".new_pc"}, new_pc_o, e_pc);
    check({tag, ".stall_cnt"}, stall_cnt_o, exp_sc);
    check({tag, ".flush_cnt"}, flush_cnt_o, exp_fc);
    if (e_stall != 4'b0000) exp_sc++;
    if (e_flush) exp_fc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    #12;
    check("reset.stall", {28'h0, stall_o}, 32'h0);
    check("reset.flush", {31'h0, flush_o}, 32'h0);
    check("reset.new_pc", new_pc_o, 32'h0);
    check("reset.stall_cnt", stall_cnt_o, 32'h0);
    @(posedge clk); #1;
    rst = 1;

    // EX multi-cycle stall for three cycles
    stallreq_ex_i = 1;
    for (int i = 0; i < 3; i++) cyc("ex_stall", 4'b0011, 0, 0, 0, 32'h0);
    stallreq_ex_i = 0;
    cyc("idle_a", 4'b0000, 0, 0, 0, 32'h0);

    // ID-only and MEM-only stall patterns
    stallreq_id_i = 1;
    cyc("id_stall", 4'b0001, 0, 0, 0, 32'h0);
    stallreq_mem_i = 1;
    cyc("mem_over_id", 4'b0111, 0, 0, 0, 32'h0);
    clear_inputs();

    // Plain mispredict, single-issue pair
    mispredict_i = 1; ex_issue_mode_i = 1; branch_pc_i = 32'hBFC0_0100;
    cyc("mispredict", 4'b0000, 1, 0, 1, 32'hBFC0_0100);
    clear_inputs();

    // Mispredict held behind an EX stall
    mispredict_i = 1; branch_pc_i = 32'h8000_0040; stallreq_ex_i = 1;
    cyc("mp_held0", 4'b0011, 0, 0, 0, 32'h0);
    cyc("mp_held1", 4'b0011, 0, 0, 0, 32'h0);
    stallreq_ex_i = 0;
    cyc("mp_release", 4'b0000, 1, 0, 0, 32'h8000_0040);
    clear_inputs();

    // Exception deferred by a 4-cycle MEM stall
    exc_req_i = 1; exc_pc_i = 32'hBFC0_0380; stallreq_mem_i = 1;
    cyc("exc_enter", 4'b0111, 0, 0, 0, 32'h0);
    exc_pc_i = 32'h1234_5678;
    for (int i = 0; i < 3; i++) cyc("exc_wait", 4'b1111, 0, 0, 0, 32'h0);
    stallreq_mem_i = 0;
    cyc("exc_wait_last", 4'b1111, 0, 0, 0, 32'h0);
    exc_req_i = 0; mispredict_i = 1; stallreq_id_i = 1;
    cyc("exc_flush", 4'b0000, 1, 1, 0, 32'hBFC0_0380);
    clear_inputs();
    cyc("idle_b", 4'b0000, 0, 0, 0, 32'h0);

    // Same-cycle exception and mispredict: only the exception flushes
    exc_req_i = 1; exc_pc_i = 32'h8000_0180; mispredict_i = 1; branch_pc_i = 32'h0000_0444;
    cyc("exc_mp_same", 4'b0000, 0, 0, 0, 32'h0);
    clear_inputs();
    cyc("exc_mp_flush", 4'b0000, 1, 1, 0, 32'h8000_0180);
    cyc("idle_c", 4'b0000, 0, 0, 0, 32'h0);

    // Reset while waiting on MEM with requests still asserted
    exc_req_i = 1; exc_pc_i = 32'hBFC0_0380; stallreq_mem_i = 1;
    cyc("wait2_enter", 4'b0111, 0, 0, 0, 32'h0);
    cyc("wait2", 4'b1111, 0, 0, 0, 32'h0);
    #1 rst = 0;
    #1;
    check("rst_mid.stall", {28'h0, stall_o}, 32'h0);
    check("rst_mid.pc_stall", {31'h0, pc_stall_o}, 32'h0);
    check("rst_mid.flush", {31'h0, flush_o}, 32'h0);
    check("rst_mid.stall_cnt", stall_cnt_o, 32'h0);
    check("rst_mid.flush_cnt", flush_cnt_o, 32'h0);
    clear_inputs();
    @(posedge clk); #1;
    rst = 1;
    exp_sc = 0; exp_fc = 0;
    cyc("after_rst", 4'b0000, 0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
